ucaspian_step_sched: RTL

- Sequences the per-timestep and clear protocols for the uCaspian datapath units (neuron, axon, synapse).
- Accepts host commands (run N steps, clear activity, clear config) and drives the shared `enable`, `next_step`, `clear_act` and `clear_config` controls.
- Waits for every unit's `step_done` / `clear_done`, counts completed steps, and returns one response per command.
- Sits between the host packet decoder and the core units.

---
 rtl/ucaspian_pkg.sv | 27 ++
 rtl/ucaspian_done_timer.sv | 36 +++
 rtl/ucaspian_step_sched.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ucaspian_pkg.sv
// Shared types for the uCaspian step scheduler: host opcodes, response codes
// and scheduler states.
package ucaspian_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_RUN     = 2'd1,
        OP_CLR_ACT = 2'd2,
        OP_CLR_CFG = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_TIMEOUT = 2'd1,
        RSP_HALT    = 2'd2
    } rsp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PULSE,
        ST_SETTLE,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/ucaspian_done_timer.sv
// Settle/timeout counter shared by the step and clear waits of the scheduler.
// Cleared by start, then counts every enabled cycle, saturating at TIMEOUT-1.
module ucaspian_done_timer #(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic count_en,
    input  logic all_done,
    output logic settled,
    output logic settle_end,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (count_en && (cnt != CW'(TIMEOUT - 1))) begin
            cnt <= cnt + CW'(1);
        end
    end

    // settled: done inputs are trustworthy this cycle; settle_end: last masked cycle
    assign settled    = (cnt >= CW'(SETTLE));
    assign settle_end = (cnt == CW'(SETTLE - 1));
    assign expired    = (cnt == CW'(TIMEOUT - 1)) && !all_done;

endmodule

// File: rtl/ucaspian_step_sched.sv
// Step/clear sequencer for the uCaspian core units: runs N timesteps or a
// clear, waits for all units' done, counts steps and returns one response.
module ucaspian_step_sched
    import ucaspian_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 3,
    parameter int unsigned STEP_W    = 16,
    parameter int unsigned TIMEOUT   = 4096,
    parameter int unsigned SETTLE    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           cmd_op,
    input  logic [STEP_W-1:0]    cmd_steps,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic                 halt,
    output logic                 enable,
    output logic                 next_step,
    input  logic [NUM_UNITS-1:0] step_done_in,
    output logic                 clear_act,
    output logic                 clear_config,
    input  logic [NUM_UNITS-1:0] clear_done_in,
    output logic [STEP_W-1:0]    step_count,
    output logic                 busy,
    output logic                 rsp_vld,
    output logic [1:0]           rsp_code,
    input  logic                 rsp_rdy
);

    state_e            state, state_d;
    logic [STEP_W-1:0] steps_left, steps_left_d, step_count_d;
    logic              clr_cfg, clr_cfg_d;
    rsp_e              rsp_q, rsp_d;

    logic step_all_done, clear_all_done;
    logic timer_start, timer_count, timer_all_done;
    logic settled, settle_end, expired;

    assign step_all_done  = &step_done_in;
    assign clear_all_done = &clear_done_in;
    assign timer_all_done = (state == ST_CLEAR) ? clear_all_done : step_all_done;
    assign timer_start    = (state_d != state) && (state_d == ST_CLEAR || state_d == ST_SETTLE);
    assign timer_count    = (state == ST_CLEAR) || (state == ST_SETTLE) || (state == ST_WAIT);

    ucaspian_done_timer #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .start      (timer_start),
        .count_en   (timer_count),
        .all_done   (timer_all_done),
        .settled    (settled),
        .settle_end (settle_end),
        .expired    (expired)
    );

    always_comb begin
        state_d      = state;
        steps_left_d = steps_left;
        step_count_d = step_count;
        clr_cfg_d    = clr_cfg;
        rsp_d        = rsp_q;
        case (state)
            ST_IDLE: begin
                if (cmd_vld && cmd_rdy) begin
                    case (op_e'(cmd_op))
                        OP_RUN: begin
                            if (cmd_steps == '0) begin
                                rsp_d   = RSP_OK;
                                state_d = ST_RESP;
                            end else begin
                                steps_left_d = cmd_steps;
                                state_d      = ST_PULSE;
                            end
                        end
                        OP_CLR_ACT, OP_CLR_CFG: begin
                            clr_cfg_d = (op_e'(cmd_op) == OP_CLR_CFG);
                            state_d   = ST_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CLEAR: begin
                if (settled && clear_all_done) begin
                    step_count_d = '0;
                    rsp_d        = RSP_OK;
                    state_d      = ST_RESP;
                end else if (expired) begin
                    rsp_d   = RSP_TIMEOUT;
                    state_d = ST_RESP;
                end
            end
            ST_PULSE: state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_end) begin
                    state_d = ST_WAIT;
                end else if (expired) begin
                    rsp_d   = RSP_TIMEOUT;
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                // halt is only looked at when a step completes, and loses to the final step
                if (step_all_done) begin
                    step_count_d = step_count + STEP_W'(1);
                    steps_left_d = steps_left - STEP_W'(1);
                    if (steps_left == STEP_W'(1)) begin
                        rsp_d   = RSP_OK;
                        state_d = ST_RESP;
                    end else if (halt) begin
                        rsp_d   = RSP_HALT;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_PULSE;
                    end
                end else if (expired) begin
                    rsp_d   = RSP_TIMEOUT;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            steps_left   <= '0;
            step_count   <= '0;
            clr_cfg      <= 1'b0;
            rsp_q        <= RSP_OK;
            cmd_rdy      <= 1'b1;
            busy         <= 1'b0;
            enable       <= 1'b0;
            next_step    <= 1'b0;
            clear_act    <= 1'b0;
            clear_config <= 1'b0;
            rsp_vld      <= 1'b0;
        end else begin
            state        <= state_d;
            steps_left   <= steps_left_d;
            step_count   <= step_count_d;
            clr_cfg      <= clr_cfg_d;
            rsp_q        <= rsp_d;
            cmd_rdy      <= (state_d == ST_IDLE);
            busy         <= (state_d != ST_IDLE);
            enable       <= (state_d == ST_PULSE) || (state_d == ST_SETTLE) || (state_d == ST_WAIT);
            next_step    <= (state_d == ST_PULSE);
            clear_act    <= (state_d == ST_CLEAR) && !clr_cfg_d;
            clear_config <= (state_d == ST_CLEAR) && clr_cfg_d;
            rsp_vld      <= (state_d == ST_RESP);
        end
    end

    assign rsp_code = rsp_q;

endmodule
